// File: rtl/reg_file_mp.sv
// reg_file_mp: dual-write, NRD-read register file that clears itself with a one-register-per-cycle sweep after reset.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NRD*AW-1:0]    r_addr,
  output logic [NRD*XLEN-1:0]  r_data,
  input  logic                 w0_en,
  input  logic [AW-1:0]        w0_addr,
  input  logic [XLEN-1:0]      w0_data,
  input  logic                 w1_en,
  input  logic [AW-1:0]        w1_addr,
  input  logic [XLEN-1:0]      w1_data,
  output logic                 ready
);
  typedef enum logic {INIT, RUN} state_t;
  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_ready;
  logic [XLEN-1:0] r_mem [NREG];
  logic            w_run, w_we0, w_we1;
  assign w_run = r_state == RUN;
  assign w_we0 = w_run && w0_en && w0_addr != '0 && int'(w0_addr) < NREG;
  assign w_we1 = w_run && w1_en && w1_addr != '0 && int'(w1_addr) < NREG;
  assign ready = r_ready;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (int'(r_cnt) == NREG - 1) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end
    end
  end
  // Storage has no reset; w1 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (!w_run) r_mem[r_cnt] <= '0;
      else begin
        if (w_we0) r_mem[w0_addr] <= w0_data;
        if (w_we1) r_mem[w1_addr] <= w1_data;
      end
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_a;
    logic          w_ok;
    assign w_a  = r_addr[k*AW +: AW];
    assign w_ok = w_run && w_a != '0 && int'(w_a) < NREG;
`ifdef REG_FILE_BYPASS_EN
    assign r_data[k*XLEN +: XLEN] = !w_ok ? '0 :
                                    (w_we1 && w1_addr == w_a) ? w1_data :
                                    (w_we0 && w0_addr == w_a) ? w0_data : r_mem[w_a];
`else
    assign r_data[k*XLEN +: XLEN] = w_ok ? r_mem[w_a] : '0;
`endif
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: random + directed check of reg_file_mp (NREG=32 and NREG=24 instances) against an array model.
module tb_reg_file_mp;
  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NR [2] = '{32, 24};
  logic clk = 0;
  logic rstn = 0;
  always #5 clk = ~clk;
  logic [NRD*AW-1:0]   r_addr;
  logic [NRD*XLEN-1:0] rd_a, rd_b;
  logic                rdy_a, rdy_b;
  logic                w0_en, w1_en;
  logic [AW-1:0]       w0_addr, w1_addr;
  logic [XLEN-1:0]     w0_data, w1_data;
  reg_file_mp #(.XLEN(XLEN), .NREG(32), .AW(AW), .NRD(NRD)) u_a (
    .clk(clk), .rstn(rstn), .r_addr(r_addr), .r_data(rd_a),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data), .ready(rdy_a));
  reg_file_mp #(.XLEN(XLEN), .NREG(24), .AW(AW), .NRD(NRD)) u_b (
    .clk(clk), .rstn(rstn), .r_addr(r_addr), .r_data(rd_b),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data), .ready(rdy_b));
  logic [XLEN-1:0] m_mem [2][32];
  int              m_cnt [2];
  bit              m_rdy [2];
  int errs = 0;
  int checks = 0;
  int n;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] m_read(input int d, input int a);
    if (!m_rdy[d] || a == 0 || a >= NR[d]) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (w1_en && int'(w1_addr) == a) return w1_data;
    if (w0_en && int'(w0_addr) == a) return w0_data;
`endif
    return m_mem[d][a];
  endfunction
  task automatic rdaddr(input int a0, input int a1);
    r_addr = {AW'(a1), AW'(a0)};
  endtask
  task automatic clr();
    w0_en = 0;
    w1_en = 0;
  endtask
  // Called just after a falling edge with inputs set: compare, then apply the rising edge to the model.
  task automatic step();
    #1;
    if (!rstn) for (int d = 0; d < 2; d++) begin m_cnt[d] = 0; m_rdy[d] = 0; end
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rd_a_p%0d", k), rd_a[k*XLEN +: XLEN], m_read(0, int'(r_addr[k*AW +: AW])));
      chk($sformatf("rd_b_p%0d", k), rd_b[k*XLEN +: XLEN], m_read(1, int'(r_addr[k*AW +: AW])));
    end
    chk("ready_a", 64'(rdy_a), 64'(m_rdy[0]));
    chk("ready_b", 64'(rdy_b), 64'(m_rdy[1]));
    @(posedge clk);
    if (rstn) for (int d = 0; d < 2; d++) begin
      if (!m_rdy[d]) begin
        m_mem[d][m_cnt[d]] = '0;
        m_cnt[d]++;
        if (m_cnt[d] == NR[d]) m_rdy[d] = 1;
      end else begin
        if (w0_en && w0_addr != 0 && int'(w0_addr) < NR[d]) m_mem[d][w0_addr] = w0_data;
        if (w1_en && w1_addr != 0 && int'(w1_addr) < NR[d]) m_mem[d][w1_addr] = w1_data;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    r_addr = '0; w0_addr = '0; w1_addr = '0; w0_data = '0; w1_data = '0;
    clr();
    for (int d = 0; d < 2; d++) begin m_cnt[d] = 0; m_rdy[d] = 0; end
    @(negedge clk);
    step();
    #1 chk("rst_ready", 64'(rdy_a), 0);
    step();
    rstn = 1;
    w0_en = 1; w0_addr = 5; w0_data = 64'hDEAD; rdaddr(5, 0);
    n = 0;
    while (!rdy_a && n < 100) begin step(); n++; end
    chk("init_len", 64'(n), 32);
    clr(); rdaddr(5, 1);
    #1 chk("x5_after_init", rd_a[63:0], 0);
    step();
    w0_en = 1; w0_addr = 3; w0_data = 64'h1234;
    w1_en = 1; w1_addr = 7; w1_data = 64'hABCD;
    step();
    clr(); rdaddr(3, 7);
    #1 chk("x3", rd_a[63:0], 64'h1234);
    chk("x7", rd_a[127:64], 64'hABCD);
    step();
    w0_en = 1; w0_addr = 9; w0_data = 64'h1111;
    w1_en = 1; w1_addr = 9; w1_data = 64'h2222;
    step();
    w0_en = 0; w1_addr = 0; w1_data = 64'hFFFF; rdaddr(9, 0);
    #1 chk("x9_w1_wins", rd_a[63:0], 64'h2222);
    step();
    clr(); rdaddr(0, 0);
    #1 chk("x0_zero", rd_a[63:0], 0);
    step();
    w0_en = 1; w0_addr = 4; w0_data = 64'h55;
    step();
    w0_data = 64'h66; rdaddr(4, 4);
`ifdef REG_FILE_BYPASS_EN
    #1 chk("x4_write_cycle", rd_a[63:0], 64'h66);
`else
    #1 chk("x4_write_cycle", rd_a[63:0], 64'h55);
`endif
    step();
    clr();
    #1 chk("x4_after", rd_a[127:64], 64'h66);
    step();
    w0_en = 1; w0_addr = 30; w0_data = 64'hBEEF; rdaddr(30, 30);
    step();
    clr();
    #1 chk("b_x30_oob", rd_b[63:0], 0);
    chk("a_x30", rd_a[63:0], 64'hBEEF);
    step();
    rstn = 0;
    step();
    rstn = 1;
    repeat (10) step();
    rstn = 0; w0_en = 1; w0_addr = 3; w0_data = 64'h77;
    #1 chk("mid_rst_ready", 64'(rdy_a), 0);
    step();
    clr(); rstn = 1; rdaddr(3, 3);
    n = 0;
    while (!rdy_a && n < 100) begin step(); n++; end
    chk("reinit_len", 64'(n), 32);
    #1 chk("x3_cleared", rd_a[63:0], 0);
    step();
    repeat (600) begin
      rstn = $urandom_range(199) != 0;
      w0_en = 1'($urandom_range(1));
      w1_en = 1'($urandom_range(1));
      w0_addr = AW'($urandom_range(31));
      w1_addr = $urandom_range(3) == 0 ? w0_addr : AW'($urandom_range(31));
      w0_data = {$urandom, $urandom};
      w1_data = {$urandom, $urandom};
      rdaddr($urandom_range(3) == 0 ? int'(w0_addr) : int'($urandom_range(31)),
             $urandom_range(3) == 0 ? int'(w1_addr) : int'($urandom_range(31)));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
